ring_sched8: RTL

RING_SCHED8 -- requirements
Module: ring_sched8

---
 rtl/ring_sched_pkg.sv | 24 ++
 rtl/ring_sched8_if.sv | 27 ++
 rtl/ring_sched8_rr_pick8.sv | 45 ++++
 rtl/ring_sched8.sv | 120 ++++++++++++
 4 files changed

// File: rtl/ring_sched_pkg.sv
// ring_sched_pkg
//   Shared definitions for the 8-way rotating-priority scheduler.
//   - RING_W / IDX_W : ring width and matching index width
//   - MAX_HOLD_DEF   : default grant hold limit in cycles
//   - state_t        : scheduler FSM encoding (IDLE / GRANT / GAP)
//   - rot1()         : one-position ring rotation, left = toward the MSB
package ring_sched_pkg;

  localparam int RING_W       = 8;
  localparam int IDX_W        = $clog2(RING_W);
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Rotate by one position; left moves bit 7 into bit 0, right moves bit 0 into bit 7.
  function automatic logic [RING_W-1:0] rot1(input logic [RING_W-1:0] v, input logic left);
    rot1 = left ? {v[RING_W-2:0], v[RING_W-1]} : {v[0], v[RING_W-1:1]};
  endfunction

endpackage

// File: rtl/ring_sched8_if.sv
// ring_sched8_if
//   Request/grant bundle between the requesters and the scheduler.
//   Requester side (master) drives: en, up_dnN, req, done.
//   Scheduler side (slave) drives : grant, busy, timeout, ptr.
interface ring_sched8_if;
  import ring_sched_pkg::*;

  logic              en;
  logic              up_dnN;
  logic [RING_W-1:0] req;
  logic              done;
  logic [RING_W-1:0] grant;
  logic              busy;
  logic              timeout;
  logic [RING_W-1:0] ptr;

  modport master (
    output en, up_dnN, req, done,
    input  grant, busy, timeout, ptr
  );

  modport slave (
    input  en, up_dnN, req, done,
    output grant, busy, timeout, ptr
  );

endinterface

// File: rtl/ring_sched8_rr_pick8.sv
// rr_pick8
//   Combinational rotating-priority search over an 8-bit request ring.
//   Ports:
//     req    [7:0] in  : request lines
//     ptr    [7:0] in  : one-hot starting position of the search
//     up_dnN        in  : 1 = step toward bit 7, 0 = step toward bit 0 (wrapping)
//     winner [7:0] out : one-hot first requester found, or zero when req is zero
module rr_pick8
  import ring_sched_pkg::*;
(
  input  logic [RING_W-1:0] req,
  input  logic [RING_W-1:0] ptr,
  input  logic              up_dnN,
  output logic [RING_W-1:0] winner
);

  logic [IDX_W-1:0]  w_base;
  logic [IDX_W-1:0]  w_pos [RING_W];
  logic [RING_W-1:0] w_hit;

  always_comb begin
    w_base = '0;
    for (int i = 0; i < RING_W; i++) begin
      if (ptr[i]) w_base = IDX_W'(i);
    end
  end

  // Search step gi looks at ring position base +/- gi; index arithmetic wraps naturally.
  for (genvar gi = 0; gi < RING_W; gi++) begin : g_step
    assign w_pos[gi] = up_dnN ? (w_base + IDX_W'(gi)) : (w_base - IDX_W'(gi));
    assign w_hit[gi] = req[w_pos[gi]];
  end

  // Walk from the farthest step to the nearest so the nearest hit wins.
  always_comb begin
    winner = '0;
    for (int k = RING_W - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        winner           = '0;
        winner[w_pos[k]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ring_sched8.sv
// ring_sched8
//   8-requester rotating-priority scheduler with a grant hold limit.
//   Ports:
//     clk   in : clock, all state updates on its rising edge
//     reset in : asynchronous active-high reset
//     bus       : ring_sched8_if.slave
//       en, up_dnN, req[7:0], done   in
//       grant[7:0], busy, timeout, ptr[7:0]   out (all registered)
//   Parameter MAX_HOLD (2..255): cycles a grant may be held before forced release.
module ring_sched8
  import ring_sched_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic         clk,
  input  logic         reset,
  ring_sched8_if.slave bus
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [RING_W-1:0] r_grant;
  logic [RING_W-1:0] w_grant_next;
  logic [RING_W-1:0] r_ptr;
  logic [RING_W-1:0] w_ptr_next;
  logic [7:0]        r_cnt;
  logic [7:0]        w_cnt_next;
  logic              r_busy;
  logic              r_timeout;
  logic              w_timeout_next;

  logic [RING_W-1:0] w_winner;
  logic              w_limit;
  logic              w_req_lost;
  logic              w_release;

  rr_pick8 u_pick (
    .req    (bus.req),
    .ptr    (r_ptr),
    .up_dnN (bus.up_dnN),
    .winner (w_winner)
  );

  assign w_limit    = (r_cnt == HOLD_LAST);
  assign w_req_lost = ((bus.req & r_grant) == '0);
  assign w_release  = bus.done || w_req_lost || w_limit;

  // State register: everything freezes while en is low, except timeout which
  // must never stretch beyond one enabled cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_ptr     <= RING_W'(1);
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else if (bus.en) begin
      r_state   <= w_state_next;
      r_grant   <= w_grant_next;
      r_ptr     <= w_ptr_next;
      r_cnt     <= w_cnt_next;
      r_busy    <= (w_state_next == ST_GRANT);
      r_timeout <= w_timeout_next;
    end else begin
      r_timeout <= 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.req != '0) w_state_next = ST_GRANT;
      ST_GRANT: if (w_release)     w_state_next = ST_GAP;
      ST_GAP:                      w_state_next = ST_IDLE;
      default:                     w_state_next = ST_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    w_grant_next   = r_grant;
    w_ptr_next     = r_ptr;
    w_cnt_next     = r_cnt;
    w_timeout_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req != '0) begin
          w_grant_next = w_winner;
          w_cnt_next   = '0;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_grant_next   = '0;
          w_ptr_next     = rot1(r_grant, bus.up_dnN);
          // Only a release caused purely by the hold limit is reported.
          w_timeout_next = w_limit && !bus.done && !w_req_lost;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      ST_GAP: begin
        w_grant_next = '0;
      end
      default: begin
        w_grant_next = '0;
      end
    endcase
  end

  assign bus.grant   = r_grant;
  assign bus.busy    = r_busy;
  assign bus.timeout = r_timeout;
  assign bus.ptr     = r_ptr;

endmodule
